// File: rtl/rgmii_inband_status.sv
// RGMII in-band status decoder: debounces the PHY idle status word and drives the MAC speed selects.
// Latency: outputs update on the edge capturing the STABLE_CNT-th matching idle sample; all registered.
// Backpressure: none; rx_dv/rx_er cycles only pause the debounce. Optional watchdog: RGMII_INBAND_TIMEOUT_EN.
module rgmii_inband_status #(
    parameter int STABLE_CNT     = 16,
    parameter int TIMEOUT_CYCLES = 1250000
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       rx_dv,
    input  logic       rx_er,
    input  logic [3:0] rxd,
    input  logic       irq_clear,
    output logic       mac_set_10,
    output logic       mac_set_1000,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       link_duplex,
    output logic       link_irq,
    output logic [7:0] change_count
);

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CNT);

    if (STABLE_CNT < 2 || STABLE_CNT > 255 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("rgmii_inband_status: parameter out of range");
    end

    logic [3:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic       up_q, up_d;
    logic [1:0] speed_q, speed_d;
    logic       duplex_q, duplex_d;
    logic       set10_q, set10_d;
    logic       set1000_q, set1000_d;
    logic       irq_q, irq_d;
    logic [7:0] chg_q, chg_d;
    logic       idle, commit, change;

`ifdef RGMII_INBAND_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
    logic [WD_W-1:0] wdog_q, wdog_d;
`endif

    always_comb begin
        idle      = !rx_dv && !rx_er;
        commit    = 1'b0;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        up_d      = up_q;
        speed_d   = speed_q;
        duplex_d  = duplex_q;

        if (idle) begin
            if (rxd[2:1] == 2'b11) begin
                cand_d = 4'd0;
                cnt_d  = 8'd0;
            end else if (rxd == cand_q) begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 8'd1;
                end
                // Committed word is compared as {duplex, speed, link}; a saturated counter never gets here.
                commit = (cnt_q == CNT_MAX - 8'd1) && (cand_q != {duplex_q, speed_q, up_q});
            end else begin
                cand_d = rxd;
                cnt_d  = 8'd1;
            end
        end

        if (commit) begin
            up_d = cand_q[0];
            if (cand_q[0]) begin
                speed_d  = cand_q[2:1];
                duplex_d = cand_q[3];
            end
        end

`ifdef RGMII_INBAND_TIMEOUT_EN
        wdog_d = wdog_q + 1'b1;
        if (idle && rxd[2:1] != 2'b11) begin
            wdog_d = '0;
        end else if (wdog_q == WD_LAST) begin
            wdog_d = '0;
            if (up_q) begin
                up_d   = 1'b0;
                cand_d = 4'd0;
                cnt_d  = 8'd0;
            end
        end
`endif

        change    = (up_d != up_q) || (speed_d != speed_q);
        irq_d     = change ? 1'b1 : (irq_clear ? 1'b0 : irq_q);
        chg_d     = chg_q + {7'd0, change};
        set1000_d = (speed_d == 2'b10);
        set10_d   = (speed_d == 2'b00);
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            cand_q    <= 4'd0;
            cnt_q     <= 8'd0;
            up_q      <= 1'b0;
            speed_q   <= 2'b01;
            duplex_q  <= 1'b0;
            set10_q   <= 1'b0;
            set1000_q <= 1'b0;
            irq_q     <= 1'b0;
            chg_q     <= 8'd0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            up_q      <= up_d;
            speed_q   <= speed_d;
            duplex_q  <= duplex_d;
            set10_q   <= set10_d;
            set1000_q <= set1000_d;
            irq_q     <= irq_d;
            chg_q     <= chg_d;
        end
    end

`ifdef RGMII_INBAND_TIMEOUT_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`endif

    assign mac_set_10   = set10_q;
    assign mac_set_1000 = set1000_q;
    assign link_up      = up_q;
    assign link_speed   = speed_q;
    assign link_duplex  = duplex_q;
    assign link_irq     = irq_q;
    assign change_count = chg_q;

endmodule

// File: doc/rgmii_inband_status.md
# rgmii_inband_status

Decodes the RGMII in-band link status that the PHY drives on RXD during inter-frame gaps, debounces it, and produces the speed-select inputs for the triple-speed MAC's status connection (`mac_status_connection_set_10` / `mac_status_connection_set_1000`). It also provides committed link, speed and duplex indications, a sticky change interrupt and a change counter.
- Sits directly upstream of the MAC.
- Runs in the RGMII receive clock domain, on the SDR receive signals produced after the DDIO input stage.

## Interface
Parameters:
- `STABLE_CNT`, 16: number of consecutive identical valid idle samples required before a status word is committed; range 2..255.
- `TIMEOUT_CYCLES`, 1250000: watchdog period in clocks (10 ms at 125 MHz); used only when `RGMII_INBAND_TIMEOUT_EN` is defined.

Ports:
- `clk_clk`  in  1  RGMII receive clock (same net as `mac_rx_clock_connection_clk`).
- `reset_reset`  in  1  synchronous, active-high reset.
- `rx_dv`  in  1  decoded RX_DV (rising-edge RX_CTL).
- `rx_er`  in  1  decoded RX_ER (RX_CTL rise XOR fall).
- `rxd`  in  4  rising-edge RXD nibble.
- `irq_clear`  in  1  one-cycle pulse; clears `link_irq`.
- `mac_set_10`  out  1  to `mac_status_connection_set_10`.
- `mac_set_1000`  out  1  to `mac_status_connection_set_1000`.
- `link_up`  out  1  committed link state.
- `link_speed`  out  2  committed speed: 00 = 10M, 01 = 100M, 10 = 1000M.
- `link_duplex`  out  1  committed duplex; 1 = full.
- `link_irq`  out  1  sticky change flag.
- `change_count`  out  8  number of committed changes; wraps.

Clocking and reset: one clock; reset is synchronous and active-high.

## Operation
- **Idle sample.** A cycle with `rx_dv`=0 and `rx_er`=0.
  - Sample word S = {`rxd`[3] duplex, `rxd`[2:1] speed, `rxd`[0] link}.
  - All other cycles are non-idle. On non-idle cycles the candidate and counter hold, so frames do not break stability.
- **Invalid sample.** An idle sample with speed = 11.
  - Clears the candidate and sets the counter to 0.
  - Never commits.
- **Valid idle sample with S == candidate.** Counter increments, saturating at `STABLE_CNT`.
- **Valid idle sample with S != candidate.** Candidate ← S; counter ← 1.
- **Commit.** Occurs on the edge where the counter becomes `STABLE_CNT` and the candidate differs from the committed word.
  - If link = 1: `link_up` ← 1; `link_speed` and `link_duplex` ← candidate fields.
  - If link = 0: `link_up` ← 0. `link_speed` and `link_duplex` hold their last values, so the MAC mode does not churn while the link is down.
  - A saturated counter never re-commits.
- **Change event.** A commit that alters `link_up` or `link_speed`.
  - Sets `link_irq`.
  - Increments `change_count` (255 wraps to 0).
  - A duplex-only change updates `link_duplex` without raising a change event.
- **MAC speed select.** Registered, follows the committed speed:
  - `mac_set_1000` = (`link_speed` == 10).
  - `mac_set_10` = (`link_speed` == 00).
  - 100M gives both 0.
- **Interrupt clear.** `irq_clear` clears `link_irq`. If a change event and `irq_clear` occur in the same cycle, the set wins.
- **Reset values**, including reset mid-operation:
  - `link_up`=0, `link_speed`=01, `link_duplex`=0, `mac_set_10`=0, `mac_set_1000`=0, `link_irq`=0, `change_count`=0.
  - Candidate = 0, counter = 0, watchdog = 0.

## Timing
- All outputs are registered.
- Commit latency: outputs change on the same edge that captures the `STABLE_CNT`-th consecutive matching valid idle sample. They are visible in the following cycle.
- Non-idle cycles between samples extend wall-clock latency but do not reset the count.
- `link_irq`, `change_count` and `mac_set_*` update on the same edge as `link_up` / `link_speed`.
- `irq_clear` takes effect at the next edge.

## Configuration
- **`RGMII_INBAND_TIMEOUT_EN` defined:** a watchdog counts clocks since the last valid idle sample and is cleared by each valid idle sample.
  - When it reaches `TIMEOUT_CYCLES` with `link_up`=1, a link-down commit is forced: `link_up` ← 0, a change event fires, candidate and counter are cleared, and the watchdog restarts.
  - With `link_up`=0 it only restarts.
- **Macro undefined:** no watchdog logic is built, and committed status holds indefinitely without idle samples.

## Test plan
- Reset applied → `link_up`=0, `link_speed`=01, `mac_set_10`=0, `mac_set_1000`=0, `link_irq`=0, `change_count`=0.
- 16 idle samples of `rxd`=1101 → no change after the 15th sample. After the 16th edge: `link_up`=1, `link_speed`=10, `link_duplex`=1, `mac_set_1000`=1, `link_irq`=1, `change_count`=1.
- Ten samples of 1101, one sample of 0001, then 1101 repeated → commit occurs only after 16 further consecutive 1101 samples.
- Same 16 samples of 1101, but with 40-cycle `rx_dv`=1 bursts between samples → same commit, once the 16th idle sample is captured.
- 32 idle samples of 0111 (reserved speed) after link up at 1000M → no output change, `change_count` unchanged.
- With the macro defined and `TIMEOUT_CYCLES`=100: link up at 1000M, then `rx_dv` held at 1 → `link_up`=0 after edge 100, `change_count` +1, `mac_set_1000` stays 1. In the same build, `irq_clear` asserted on that edge → `link_irq`=1.
- With the macro undefined, the same stimulus → `link_up` stays 1.
